// File: rtl/falu_issue_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : falu_issue_sequencer
// Brief    : Launches multi-cycle FALU ops from decode, stalls decode on FP
//            RAW/WAW and structural hazards, and arbitrates the FP regfile
//            write port against FLW writeback (FLW wins).
// Revision : 1.0  initial release
// ============================================================================
module falu_issue_sequencer #(
    parameter int FALU_LAT = 3,
    parameter int RAW      = 5,
    parameter int DW       = 32
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           id_valid,
    input  logic           id_falu_en,
    input  logic           id_flush,
    input  logic [RAW-1:0] id_rs1,
    input  logic [RAW-1:0] id_rs2,
    input  logic [RAW-1:0] id_rd,
    input  logic           id_frs1_use,
    input  logic           id_frs2_use,
    input  logic           id_frd_write,
    output logic           id_stall,
    output logic           falu_start,
    input  logic [DW-1:0]  falu_result,
    input  logic           mem_fwb_valid,
    output logic           fp_wb_en,
    output logic [RAW-1:0] fp_wb_rd,
    output logic [DW-1:0]  fp_wb_data,
    output logic           busy,
    output logic [15:0]    stall_cnt
);

    localparam logic [1:0] c_IDLE     = 2'd0;
    localparam logic [1:0] c_BUSY     = 2'd1;
    localparam logic [1:0] c_WB_PEND  = 2'd2;
    localparam logic [3:0] c_CNT_INIT = 4'(FALU_LAT - 1);

    logic [1:0]     r_state;
    logic [1:0]     w_state_nxt;
    logic [3:0]     r_cnt;
    logic [RAW-1:0] r_rd_q;
    logic [DW-1:0]  r_res_q;
    logic [15:0]    r_stall_cnt;

    logic           w_busy;
    logic           w_haz;
    logic           w_stall;
    logic           w_issue;
    logic           w_complete;
    logic           w_start;
    logic           w_wb_en;
    logic [DW-1:0]  w_wb_data;

    assign w_busy     = (r_state != c_IDLE);
    assign w_haz      = (id_frs1_use  && (id_rs1 == r_rd_q)) ||
                        (id_frs2_use  && (id_rs2 == r_rd_q)) ||
                        (id_frd_write && (id_rd  == r_rd_q));
    // Any FALU op waits for the single unit; other instructions only wait on a register clash.
    assign w_stall    = id_valid && !id_flush && w_busy && (id_falu_en || w_haz);
    // Reset gating keeps a launch from escaping while the state is being cleared.
    assign w_issue    = id_valid && id_falu_en && !id_flush && !w_stall && !rst;
    assign w_complete = (r_state == c_BUSY) && (r_cnt == 4'd0);

    // Next-state and port-arbitration decisions.
    always_comb begin
        w_state_nxt = r_state;
        w_start     = 1'b0;
        w_wb_en     = 1'b0;
        w_wb_data   = r_res_q;
        case (r_state)
            c_IDLE: begin
                if (w_issue) begin
                    w_start     = 1'b1;
                    w_state_nxt = c_BUSY;
                end
            end
            c_BUSY: begin
                if (r_cnt == 4'd0) begin
                    // Completion cycle: result is live on the FALU bus, bypass it.
                    w_wb_data = falu_result;
                    if (!mem_fwb_valid) begin
                        w_wb_en     = 1'b1;
                        w_state_nxt = c_IDLE;
                    end else begin
                        w_state_nxt = c_WB_PEND;
                    end
                end
            end
            c_WB_PEND: begin
                if (!mem_fwb_valid) begin
                    w_wb_en     = 1'b1;
                    w_state_nxt = c_IDLE;
                end
            end
            default: begin
                w_state_nxt = c_IDLE;
            end
        endcase
    end

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= c_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Latency counter, destination and captured result.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt   <= 4'd0;
            r_rd_q  <= '0;
            r_res_q <= '0;
        end else begin
            if (w_start) begin
                r_rd_q <= id_rd;
                r_cnt  <= c_CNT_INIT;
            end else if ((r_state == c_BUSY) && (r_cnt != 4'd0)) begin
                r_cnt <= r_cnt - 4'd1;
            end
            if (w_complete) begin
                r_res_q <= falu_result;
            end
        end
    end

    // Saturating count of decode stall cycles.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_stall_cnt <= 16'd0;
        end else if (w_stall && (r_stall_cnt != 16'hFFFF)) begin
            r_stall_cnt <= r_stall_cnt + 16'd1;
        end
    end

    assign id_stall   = w_stall;
    assign falu_start = w_start;
    assign fp_wb_en   = w_wb_en && !rst;
    assign fp_wb_rd   = r_rd_q;
    assign fp_wb_data = w_wb_data;
    assign busy       = w_busy;
    assign stall_cnt  = r_stall_cnt;

endmodule
`default_nettype wire
